// File: rtl/game_sequencer.sv
// Breakout game-flow controller: credits, 1/2-player start, per-player ball count
// and serve/game-over frame timing, all as one FSM clocked by CLK_DRV.
module game_sequencer #(
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int GAMEOVER_FRAMES    = 120,
    parameter int MAX_CREDITS        = 9
) (
    input  logic       CLK_DRV,
    input  logic       RESET_N,
    input  logic       FRAME_TICK,
    input  logic       COIN,
    input  logic       START1_N,
    input  logic       START2_N,
    input  logic       SERVE_N,
    input  logic       BALL_MISS,
    input  logic       S4,
    output logic       ATTRACT,
    output logic       START_GAME1_N,
    output logic       SERVE_WAIT,
    output logic       SERVE_STB,
    output logic       PLAYER2,
    output logic       TWO_PLAYER,
    output logic [2:0] BALL_NUM,
    output logic       GAME_OVER,
    output logic       EGL,
    output logic [3:0] CREDITS,
    output logic [2:0] STATE_DBG
);

    localparam int MAX_FRAMES = (SERVE_DELAY_FRAMES > GAMEOVER_FRAMES) ?
                                SERVE_DELAY_FRAMES : GAMEOVER_FRAMES;
    localparam int CW = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_ATTRACT    = 3'd0,
        ST_START      = 3'd1,
        ST_SERVE_WAIT = 3'd2,
        ST_IN_PLAY    = 3'd3,
        ST_BALL_LOST  = 3'd4,
        ST_GAME_OVER  = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic            coin_q, start1_q, start2_q, serve_q;
    logic            coin_edge, start1_edge, start2_edge, serve_edge;
    logic [3:0]      credits, credits_nxt;
    logic [4:0]      credits_sum;
    logic [1:0]      cost;
    logic [CW-1:0]   frame_cnt, frame_cnt_nxt;
    logic [2:0]      n_balls, n_balls_nxt;
    logic [2:0]      ball_p1, ball_p1_nxt, ball_p2, ball_p2_nxt;
    logic [2:0]      cur_ball, ball_num;
    logic            done_p1, done_p1_nxt, done_p2, done_p2_nxt;
    logic            cur_done, other_done;
    logic            player2, player2_nxt, two_player, two_player_nxt;
    logic            serve_stb, serve_stb_nxt, egl, egl_nxt;

    // Edges compare against last cycle's sample; idle levels are COIN=0 and buttons high.
    assign coin_edge   = COIN & ~coin_q;
    assign start1_edge = ~START1_N & start1_q;
    assign start2_edge = ~START2_N & start2_q;
    assign serve_edge  = ~SERVE_N & serve_q;

    assign cur_ball   = player2 ? ball_p2 : ball_p1;
    assign cur_done   = (cur_ball >= n_balls);
    assign other_done = player2 ? done_p1 : done_p2;

    always_comb begin
        state_nxt      = state;
        cost           = 2'd0;
        frame_cnt_nxt  = frame_cnt;
        n_balls_nxt    = n_balls;
        ball_p1_nxt    = ball_p1;
        ball_p2_nxt    = ball_p2;
        done_p1_nxt    = done_p1;
        done_p2_nxt    = done_p2;
        player2_nxt    = player2;
        two_player_nxt = two_player;
        serve_stb_nxt  = 1'b0;
        egl_nxt        = 1'b0;

        case (state)
            ST_ATTRACT: begin
                if (start2_edge && credits >= 4'd2) begin
                    cost           = 2'd2;
                    two_player_nxt = 1'b1;
                    state_nxt      = ST_START;
                end else if (start1_edge && credits >= 4'd1) begin
                    cost           = 2'd1;
                    two_player_nxt = 1'b0;
                    state_nxt      = ST_START;
                end
                if (state_nxt == ST_START) begin
                    ball_p1_nxt = 3'd1;
                    ball_p2_nxt = 3'd1;
                    done_p1_nxt = 1'b0;
                    done_p2_nxt = 1'b0;
                    player2_nxt = 1'b0;
                end
            end
            ST_START: begin
                n_balls_nxt   = S4 ? 3'd5 : 3'd3;
                ball_p1_nxt   = 3'd1;
                ball_p2_nxt   = 3'd1;
                player2_nxt   = 1'b0;
                frame_cnt_nxt = CW'(SERVE_DELAY_FRAMES);
                state_nxt     = ST_SERVE_WAIT;
            end
            ST_SERVE_WAIT: begin
                if (frame_cnt == '0) begin
                    if (serve_edge) begin
                        serve_stb_nxt = 1'b1;
                        state_nxt     = ST_IN_PLAY;
                    end
                end else if (FRAME_TICK) begin
                    frame_cnt_nxt = frame_cnt - 1'b1;
                end
            end
            ST_IN_PLAY: begin
                if (BALL_MISS) state_nxt = ST_BALL_LOST;
            end
            ST_BALL_LOST: begin
                if (!cur_done) begin
                    if (player2) ball_p2_nxt = ball_p2 + 3'd1;
                    else         ball_p1_nxt = ball_p1 + 3'd1;
                end else begin
                    if (player2) done_p2_nxt = 1'b1;
                    else         done_p1_nxt = 1'b1;
                end
                if (two_player && !other_done) player2_nxt = ~player2;
                // A 1-player game ends as soon as player 1 runs out of balls.
                if (cur_done && (!two_player || other_done)) begin
                    egl_nxt       = 1'b1;
                    frame_cnt_nxt = CW'(GAMEOVER_FRAMES);
                    state_nxt     = ST_GAME_OVER;
                end else begin
                    frame_cnt_nxt = CW'(SERVE_DELAY_FRAMES);
                    state_nxt     = ST_SERVE_WAIT;
                end
            end
            ST_GAME_OVER: begin
                if (frame_cnt == '0) begin
                    two_player_nxt = 1'b0;
                    player2_nxt    = 1'b0;
                    state_nxt      = ST_ATTRACT;
                end else if (FRAME_TICK) begin
                    frame_cnt_nxt = frame_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_ATTRACT;
        endcase
    end

    // Deduction only happens when affordable, so the sum never underflows.
    always_comb begin
        credits_sum = {1'b0, credits} - {3'b000, cost} + {4'b0000, coin_edge};
        credits_nxt = credits_sum[3:0];
        if (credits_sum > 5'(MAX_CREDITS)) credits_nxt = 4'(MAX_CREDITS);
    end

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_ATTRACT;
            coin_q     <= 1'b0;
            start1_q   <= 1'b1;
            start2_q   <= 1'b1;
            serve_q    <= 1'b1;
            credits    <= 4'd0;
            frame_cnt  <= '0;
            n_balls    <= 3'd3;
            ball_p1    <= 3'd1;
            ball_p2    <= 3'd1;
            done_p1    <= 1'b0;
            done_p2    <= 1'b0;
            player2    <= 1'b0;
            two_player <= 1'b0;
            ball_num   <= 3'd1;
            serve_stb  <= 1'b0;
            egl        <= 1'b0;
        end else begin
            state      <= state_nxt;
            coin_q     <= COIN;
            start1_q   <= START1_N;
            start2_q   <= START2_N;
            serve_q    <= SERVE_N;
            credits    <= credits_nxt;
            frame_cnt  <= frame_cnt_nxt;
            n_balls    <= n_balls_nxt;
            ball_p1    <= ball_p1_nxt;
            ball_p2    <= ball_p2_nxt;
            done_p1    <= done_p1_nxt;
            done_p2    <= done_p2_nxt;
            player2    <= player2_nxt;
            two_player <= two_player_nxt;
            ball_num   <= player2_nxt ? ball_p2_nxt : ball_p1_nxt;
            serve_stb  <= serve_stb_nxt;
            egl        <= egl_nxt;
        end
    end

    // SERVE_STB and EGL are single-cycle strobes with no handshake: consumers
    // must sample them every cycle; START_GAME1_N is the active-low equivalent.
    assign ATTRACT       = (state == ST_ATTRACT);
    assign START_GAME1_N = (state != ST_START);
    assign SERVE_WAIT    = (state == ST_SERVE_WAIT);
    assign GAME_OVER     = (state == ST_GAME_OVER);
    assign SERVE_STB     = serve_stb;
    assign EGL           = egl;
    assign PLAYER2       = player2;
    assign TWO_PLAYER    = two_player;
    assign BALL_NUM      = ball_num;
    assign CREDITS       = credits;
    assign STATE_DBG     = state;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for Breakout.
- Owns credits, the 1-/2-player game start, the per-player ball count and the serve-delay timing.
- Drives the ATTRACT, START_GAME1_N, SERVE_WAIT, PLAYER2 and ball-number signals that the ball-serve, score and display logic consume.
- Fully synchronous to CLK_DRV; replaces ripple-clocked TTL sequencing with a single explicit FSM.

Parameters:
- SERVE_DELAY_FRAMES, 60: frames the FSM waits in SERVE_WAIT before a serve is accepted.
- GAMEOVER_FRAMES, 120: frames the FSM holds GAME_OVER before returning to attract.
- MAX_CREDITS, 9: credit counter saturation value.

Ports:
- CLK_DRV, in, 1: system clock.
- RESET_N, in, 1: asynchronous active-low reset.
- FRAME_TICK, in, 1: one-cycle pulse per video frame (vblank start).
- COIN, in, 1: coin switch, active-high level.
- START1_N, in, 1: 1-player start button, active-low level.
- START2_N, in, 1: 2-player start button, active-low level.
- SERVE_N, in, 1: serve button, active-low level.
- BALL_MISS, in, 1: one-cycle pulse when the ball exits the bottom of the field.
- S4, in, 1: balls per player; 0 = 3, 1 = 5.
- ATTRACT, out, 1: high in the ATTRACT state.
- START_GAME1_N, out, 1: active-low one-cycle pulse at game start.
- SERVE_WAIT, out, 1: high in the SERVE_WAIT state.
- SERVE_STB, out, 1: one-cycle pulse when a serve is launched.
- PLAYER2, out, 1: current player is player 2.
- TWO_PLAYER, out, 1: latched 2-player game flag.
- BALL_NUM, out, 3: current player's ball number, 1..N.
- GAME_OVER, out, 1: high in the GAME_OVER state.
- EGL, out, 1: one-cycle end-of-game pulse.
- CREDITS, out, 4: credit count.

Behaviour:
- Reset (async, RESET_N=0) sets:
  - state=ATTRACT, CREDITS=0, ATTRACT=1, START_GAME1_N=1.
  - SERVE_WAIT=0, SERVE_STB=0, PLAYER2=0, TWO_PLAYER=0, BALL_NUM=1.
  - GAME_OVER=0, EGL=0; frame counter and all edge-detect registers cleared to their idle levels.
- Reset asserted mid-game abandons the game immediately, with no EGL.
- Edge detection:
  - COIN rising edge, START1_N/START2_N falling edge, SERVE_N falling edge.
  - Each edge is detected from the previous-cycle register and acts in the cycle it is detected.
- Credits:
  - Any coin edge, in any state, increments CREDITS, saturating at MAX_CREDITS.
  - A coin edge in the same cycle as a start deduction gives net CREDITS = old − cost + 1, saturated.
- ATTRACT:
  - START2 edge with CREDITS≥2: CREDITS−=2, TWO_PLAYER=1, go to START.
  - Otherwise, START1 edge with CREDITS≥1: CREDITS−=1, TWO_PLAYER=0, go to START.
  - Both edges in the same cycle: START2 has priority if affordable.
  - Insufficient credits: ignore the edge.
- START (1 cycle):
  - START_GAME1_N=0.
  - Latch N = S4 ? 5 : 3; later S4 changes have no effect until the next game.
  - Set ball_p1=ball_p2=1, PLAYER2=0.
  - Load frame counter with SERVE_DELAY_FRAMES; go to SERVE_WAIT.
- SERVE_WAIT:
  - SERVE_WAIT=1; each FRAME_TICK decrements the counter, which stops at 0.
  - When the counter is 0 and a SERVE_N edge is detected: pulse SERVE_STB for 1 cycle, go to IN_PLAY.
  - A serve edge while the counter is nonzero is discarded.
  - BALL_MISS is ignored.
- IN_PLAY: BALL_MISS goes to BALL_LOST. Start and serve edges are ignored.
- BALL_LOST (1 cycle): let cur = the current player's ball count.
  - If cur<N, increment it.
  - Otherwise mark the current player as done.
  - If TWO_PLAYER and the other player is not done, toggle PLAYER2.
  - If all playing players are done: go to GAME_OVER, pulse EGL, load counter with GAMEOVER_FRAMES.
  - Otherwise load counter with SERVE_DELAY_FRAMES and go to SERVE_WAIT.
- BALL_NUM always shows the ball count of the player selected by PLAYER2; it is registered and valid the cycle after any change.
- GAME_OVER:
  - GAME_OVER=1; FRAME_TICK decrements the counter.
  - At 0, go to ATTRACT and clear TWO_PLAYER and PLAYER2.
  - Start edges are ignored until ATTRACT is reached.
- Outputs are registered; each is decoded from the state register with no combinational path from inputs.
- Frame counter width is $clog2(max(SERVE_DELAY_FRAMES, GAMEOVER_FRAMES)+1).

Test Plan:
- Reset with 3 coin edges, then a START1 edge → CREDITS=2, then START_GAME1_N low for exactly 1 cycle; SERVE_WAIT=1, BALL_NUM=1, PLAYER2=0.
- In SERVE_WAIT, SERVE_N edge after 59 FRAME_TICKs → no SERVE_STB; edge after the 60th → SERVE_STB single pulse, SERVE_WAIT=0.
- 1-player, S4=0: 3 serve/BALL_MISS cycles → BALL_NUM 1→2→3, then EGL pulse and GAME_OVER=1; ATTRACT=1 after 120 FRAME_TICKs.
- 2-player, S4=1, CREDITS=2, START2 edge:
  - CREDITS=0; misses alternate PLAYER2 0,1,0,1…
  - After the 10th miss, EGL fires and each player's BALL_NUM=5.
- CREDITS=9 with a COIN edge → stays 9. CREDITS=1 with START2 → ignored; START1 and COIN in the same cycle → CREDITS=1, game starts.
- Assert RESET_N during IN_PLAY → all outputs at reset values asynchronously; EGL stays 0.
